// File: rtl/apb_pkg.sv
// ============================================================================
// apb_pkg : shared APB types and constants (state encoding, widths, ID default)
// Rev 1.0
// ============================================================================
`default_nettype none

package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b10
  } state_t;

  localparam int          APB_DW       = 32;
  localparam int          APB_SW       = 4;
  localparam logic [31:0] APB_ID_VALUE = 32'hA5B0_0001;

endpackage

`default_nettype wire

// File: rtl/apb_regfile.sv
// ============================================================================
// apb_regfile : word register array with byte-strobe write, read mux, flat export
// Rev 1.0
// ============================================================================
`default_nettype none

module apb_regfile
  import apb_pkg::*;
#(
  parameter int              DW       = APB_DW,
  parameter int              NREGS    = 8,
  parameter logic [DW-1:0]   ID_VALUE = APB_ID_VALUE,
  localparam int             SW       = DW / 8,
  localparam int             c_IW     = $clog2(NREGS)
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_we,
  input  logic [c_IW-1:0]       i_widx,
  input  logic [DW-1:0]         i_wdata,
  input  logic [SW-1:0]         i_wstrb,
  input  logic [c_IW-1:0]       i_ridx,
  output logic [DW-1:0]         o_rdata,
  output logic [NREGS*DW-1:0]   o_regs
);

  logic [DW-1:0] w_regs [NREGS];

  // Index 0 is the read-only ID; it has no storage behind it.
  assign w_regs[0] = ID_VALUE;

  for (genvar gi = 1; gi < NREGS; gi++) begin : g_reg
    logic [DW-1:0] r_q;

    always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
        r_q <= '0;
      end else if (i_we && (i_widx == c_IW'(gi))) begin
        for (int b = 0; b < SW; b++) begin
          if (i_wstrb[b]) r_q[8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end

    assign w_regs[gi] = r_q;
  end

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_flat
    assign o_regs[gi*DW +: DW] = w_regs[gi];
  end

  assign o_rdata = (int'(i_ridx) < NREGS) ? w_regs[i_ridx] : '0;

endmodule

`default_nettype wire

// File: rtl/apb_slave_regs.sv
// ============================================================================
// apb_slave_regs : APB4 completer with wait states, error decode and register file
// Rev 1.0
// ============================================================================
`default_nettype none

module apb_slave_regs
  import apb_pkg::*;
#(
  parameter int            DW          = APB_DW,
  parameter int            AW          = 8,
  parameter int            NREGS       = 8,
  parameter int            WAIT_CYCLES = 0,
  parameter logic [31:0]   ID_VALUE    = APB_ID_VALUE,
  localparam int           SW          = DW / 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [AW-1:0]         i_paddr,
  input  logic                  i_pwrite,
  input  logic                  i_psel,
  input  logic                  i_penable,
  input  logic [DW-1:0]         i_pwdata,
  input  logic [SW-1:0]         i_pstrb,
  output logic [DW-1:0]         o_prdata,
  output logic                  o_pslverr,
  output logic                  o_pready,
  output logic [NREGS*DW-1:0]   o_regs
);

  localparam int          c_IW   = $clog2(NREGS);
  localparam int unsigned c_SPAN = 4 * NREGS;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_cnt;
  logic [c_IW-1:0]   r_idx;
  logic              r_write;
  logic [DW-1:0]     r_wdata;
  logic [SW-1:0]     r_strb;
  logic              r_err;
  logic [DW-1:0]     r_rdata;

  logic              w_setup;
  logic              w_done;
  logic              w_pready;
  logic              w_we;
  logic [c_IW-1:0]   w_idx;
  logic              w_oob;
  logic              w_err;
  logic [DW-1:0]     w_rd;

  // Decode is done on the live setup-phase bus; only the results are kept.
  assign w_idx = i_paddr[c_IW+1:2];
  assign w_oob = ({1'b0, i_paddr} >= (AW+1)'(c_SPAN));
  assign w_err = (|i_paddr[1:0]) | w_oob | (i_pwrite && (w_idx == '0));

  assign w_pready = (r_state == ACCESS) && (r_cnt == 4'd0);
  assign w_we     = w_done && r_write && !r_err;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) r_state <= IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_setup     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_psel && !i_penable) begin
          w_state_nxt = ACCESS;
          w_setup     = 1'b1;
        end
      end
      ACCESS: begin
        if (!i_psel) begin
          w_state_nxt = IDLE;
        end else if (i_penable && w_pready) begin
          w_state_nxt = IDLE;
          w_done      = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_cnt   <= 4'd0;
      r_idx   <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_strb  <= '0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else if (w_setup) begin
      r_cnt   <= 4'(WAIT_CYCLES);
      r_idx   <= w_idx;
      r_write <= i_pwrite;
      r_wdata <= i_pwdata;
      r_strb  <= i_pstrb;
      r_err   <= w_err;
      r_rdata <= (w_err || i_pwrite) ? '0 : w_rd;
    end else if ((r_state == ACCESS) && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  apb_regfile #(
    .DW       (DW),
    .NREGS    (NREGS),
    .ID_VALUE (ID_VALUE)
  ) u_regfile (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_we      (w_we),
    .i_widx    (r_idx),
    .i_wdata   (r_wdata),
    .i_wstrb   (r_strb),
    .i_ridx    (w_idx),
    .o_rdata   (w_rd),
    .o_regs    (o_regs)
  );

  assign o_pready  = w_pready;
  assign o_pslverr = w_pready & r_err;
  assign o_prdata  = w_pready ? r_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_apb_slave_regs.sv
// ============================================================================
// tb_apb_slave_regs : two completers (0 and 3 wait states) on a shared bus model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_apb_slave_regs;
  import apb_pkg::*;

  localparam int NR = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, psel, penable, pwrite, slow;
  logic [7:0]   paddr;
  logic [31:0]  pwdata;
  logic [3:0]   pstrb;

  logic [31:0]  prdata0, prdata3;
  logic         err0, err3, rdy0, rdy3;
  logic [255:0] regs0, regs3;

  logic         psel0, psel3, rdy, err;
  logic [31:0]  prdata;
  logic [255:0] regs;

  assign psel0  = psel & ~slow;
  assign psel3  = psel & slow;
  assign rdy    = slow ? rdy3    : rdy0;
  assign err    = slow ? err3    : err0;
  assign prdata = slow ? prdata3 : prdata0;
  assign regs   = slow ? regs3   : regs0;

  apb_slave_regs #(.WAIT_CYCLES(0)) dut0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_paddr(paddr), .i_pwrite(pwrite),
    .i_psel(psel0), .i_penable(penable), .i_pwdata(pwdata), .i_pstrb(pstrb),
    .o_prdata(prdata0), .o_pslverr(err0), .o_pready(rdy0), .o_regs(regs0)
  );

  apb_slave_regs #(.WAIT_CYCLES(3)) dut3 (
    .i_clk(clk), .i_reset_n(rst_n), .i_paddr(paddr), .i_pwrite(pwrite),
    .i_psel(psel3), .i_penable(penable), .i_pwdata(pwdata), .i_pstrb(pstrb),
    .o_prdata(prdata3), .o_pslverr(err3), .o_pready(rdy3), .o_regs(regs3)
  );

  int errors = 0;
  int checks = 0;

  // Reference register images, one per device; index 0 is never stored.
  logic [31:0] m [2][NR];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] model_image(input int d);
    logic [255:0] f;
    f = '0;
    for (int i = 0; i < NR; i++) f[i*32 +: 32] = (i == 0) ? 32'hA5B0_0001 : m[d][i];
    return f;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NR; i++) m[d][i] = '0;
  endtask

  task automatic model_xfer(input int d, input logic [7:0] a, input logic w,
                            input logic [31:0] wd, input logic [3:0] st,
                            output logic e, output logic [31:0] rd);
    int idx;
    idx = int'(a) / 4;
    e  = (a % 4 != 0) || (int'(a) >= 4 * NR) || (w && idx == 0);
    rd = '0;
    if (!e && !w) rd = (idx == 0) ? 32'hA5B0_0001 : m[d][idx];
    if (!e && w)
      for (int b = 0; b < 4; b++)
        if (st[b]) m[d][idx][8*b +: 8] = wd[8*b +: 8];
  endtask

  // Returns right after the completion edge so a following call is back-to-back.
  task automatic xfer(input logic s, input logic [7:0] a, input logic w,
                      input logic [31:0] wd, input logic [3:0] st,
                      output logic gerr, output logic [31:0] grd, output int waits);
    @(negedge clk);
    slow = s; psel = 1'b1; penable = 1'b0;
    paddr = a; pwrite = w; pwdata = wd; pstrb = st;
    @(negedge clk);
    penable = 1'b1;
    waits = 0;
    while (!rdy && waits < 40) begin
      chk("wait_prdata", 256'(prdata), 256'(0));
      chk("wait_pslverr", 256'(err), 256'(0));
      paddr  = 8'($urandom);
      pwdata = $urandom;
      pstrb  = 4'($urandom);
      pwrite = ~pwrite;
      @(negedge clk);
      waits++;
    end
    gerr = err;
    grd  = prdata;
    if (!rdy) begin
      errors++;
      $display("FAIL pready_timeout: got 0 expected 1");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic s, input logic [7:0] a, input logic w,
                     input logic [31:0] wd, input logic [3:0] st,
                     output logic gerr, output logic [31:0] grd);
    logic        e;
    logic [31:0] rd;
    int          waits;
    model_xfer(s ? 1 : 0, a, w, wd, st, e, rd);
    xfer(s, a, w, wd, st, gerr, grd, waits);
    chk("model_pslverr", 256'(gerr), 256'(e));
    if (!w) chk("model_prdata", 256'(grd), 256'(rd));
    chk("wait_count", 256'(waits), s ? 256'(3) : 256'(0));
    chk("model_regs", regs, model_image(s ? 1 : 0));
  endtask

  typedef struct {
    logic        s;
    logic [7:0]  a;
    logic        w;
    logic [31:0] wd;
    logic [3:0]  st;
    logic        e;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl [14];

  initial begin
    logic        gerr;
    logic [31:0] grd;
    int          cyc;

    tbl[0]  = '{1'b0, 8'h04, 1'b1, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 8'h04, 1'b0, 32'h0,        4'h0, 1'b0, 32'hDEADBEEF};
    tbl[2]  = '{1'b0, 8'h08, 1'b1, 32'h11223344, 4'h5, 1'b0, 32'h0};
    tbl[3]  = '{1'b0, 8'h08, 1'b0, 32'h0,        4'h0, 1'b0, 32'h00220044};
    tbl[4]  = '{1'b0, 8'h03, 1'b0, 32'h0,        4'hF, 1'b1, 32'h0};
    tbl[5]  = '{1'b0, 8'h20, 1'b0, 32'h0,        4'hF, 1'b1, 32'h0};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 32'h12345678, 4'hF, 1'b1, 32'h0};
    tbl[7]  = '{1'b0, 8'h00, 1'b0, 32'h0,        4'h0, 1'b0, 32'hA5B00001};
    tbl[8]  = '{1'b0, 8'h0C, 1'b1, 32'hFFFFFFFF, 4'h0, 1'b0, 32'h0};
    tbl[9]  = '{1'b0, 8'h0C, 1'b0, 32'h0,        4'h0, 1'b0, 32'h0};
    tbl[10] = '{1'b1, 8'h04, 1'b0, 32'h0,        4'h0, 1'b0, 32'h0};
    tbl[11] = '{1'b1, 8'h04, 1'b1, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0};
    tbl[12] = '{1'b1, 8'h04, 1'b0, 32'h0,        4'h0, 1'b0, 32'hDEADBEEF};
    tbl[13] = '{1'b1, 8'h1E, 1'b1, 32'h55555555, 4'hF, 1'b1, 32'h0};

    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; slow = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    chk("reset_pready0", 256'(rdy0), 256'(0));
    chk("reset_pready3", 256'(rdy3), 256'(0));
    chk("reset_pslverr0", 256'(err0), 256'(0));
    chk("reset_prdata0", 256'(prdata0), 256'(0));
    chk("reset_regs0", regs0, 256'h0000_0000_A5B0_0001);
    chk("reset_regs3", regs3, 256'h0000_0000_A5B0_0001);

    for (int i = 0; i < 14; i++) begin
      run(tbl[i].s, tbl[i].a, tbl[i].w, tbl[i].wd, tbl[i].st, gerr, grd);
      chk($sformatf("vec%0d_pslverr", i), 256'(gerr), 256'(tbl[i].e));
      if (!tbl[i].w) chk($sformatf("vec%0d_prdata", i), 256'(grd), 256'(tbl[i].rd));
      if (i == 0) chk("vec0_oregs_reg1", 256'(regs0[63:32]), 256'(32'hDEADBEEF));
    end

    // IDLE ignores psel with penable already high.
    @(negedge clk);
    slow = 1'b0; psel = 1'b1; penable = 1'b1; paddr = 8'h04; pwrite = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("idle_penable_ignored", 256'(rdy0), 256'(0));
    end
    psel = 1'b0; penable = 1'b0;

    // Reset on the cycle the slow write would have completed: no write.
    @(negedge clk);
    slow = 1'b1; psel = 1'b1; penable = 1'b0;
    paddr = 8'h0C; pwrite = 1'b1; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    @(negedge clk);
    penable = 1'b1;
    cyc = 0;
    while (!rdy3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("pre_reset_ready", 256'(rdy3), 256'(1));
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset_abort_pready", 256'(rdy3), 256'(0));
    rst_n = 1'b1; psel = 1'b0; penable = 1'b0;
    model_reset();
    chk("reset_abort_reg3", 256'(regs3[127:96]), 256'(0));
    chk("reset_abort_regs0", regs0, model_image(0));

    // Protocol abort: psel drops during the wait states.
    @(negedge clk);
    slow = 1'b1; psel = 1'b1; penable = 1'b0;
    paddr = 8'h10; pwrite = 1'b1; pwdata = 32'hCAFEF00D; pstrb = 4'hF;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("abort_no_pready", 256'(rdy3), 256'(0));
    end
    chk("abort_no_write", regs3, model_image(1));
    run(1'b1, 8'h10, 1'b0, 32'h0, 4'h0, gerr, grd);
    chk("abort_readback", 256'(grd), 256'(0));

    // Randomized traffic, back-to-back, across both devices.
    for (int n = 0; n < 150; n++) begin
      logic [7:0] a;
      a = 8'($urandom_range(0, 39));
      if ($urandom % 4 != 0) a[1:0] = 2'b00;
      run(1'($urandom), a, 1'($urandom), $urandom, 4'($urandom), gerr, grd);
    end

    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/apb_slave_regs.md
Name: apb_slave_regs

Overview:
- APB4 completer: a small memory-mapped register file answering transfers from an APB requester (e.g. apb_master).
- Provides NREGS word registers: a read-only ID register at offset 0, plus read/write control registers with byte-strobe writes.
- Inserts a programmable number of wait states and flags PSLVERR on illegal accesses.
- Sits on the peripheral side of the APB bus; register contents are exported flat to the local logic.

Parameters:
- DW, 32, data width; fixed at 32. SW = DW/8 is a derived localparam.
- AW, 8, address width; must satisfy 2^AW >= 4*NREGS.
- NREGS, 8, number of word registers; 2..64.
- WAIT_CYCLES, 0, wait states added to every access; 0..15.
- ID_VALUE, 32'hA5B0_0001, constant returned by register 0.

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  synchronous reset, active-low
- i_paddr  in  AW  byte address
- i_pwrite  in  1  1 = write, 0 = read
- i_psel  in  1  select
- i_penable  in  1  access phase
- i_pwdata  in  DW  write data
- i_pstrb  in  SW  write byte strobes
- o_prdata  out  DW  read data; valid while o_pready=1
- o_pslverr  out  1  error response; valid while o_pready=1
- o_pready  out  1  transfer complete
- o_regs  out  NREGS*DW  flat register contents; reg i occupies bits [i*DW +: DW]

Behaviour:
- Reset is synchronous: i_reset_n=0 sampled at a rising i_clk edge.
  - State goes to IDLE and the wait counter to 0.
  - o_pready, o_pslverr and o_prdata are 0.
  - Registers 1..NREGS-1 are 0; the register 0 slice of o_regs always reads ID_VALUE.
  - Reset during ACCESS abandons the transfer with no write.
- FSM states: IDLE, ACCESS.
  - IDLE -> ACCESS on a rising edge with i_psel=1 and i_penable=0 (setup phase).
  - At that edge, capture paddr/pwrite/pwdata/pstrb, load cnt = WAIT_CYCLES, and precompute err and rdata into registers.
  - In ACCESS with cnt>0: cnt decrements by 1 per cycle.
  - o_pready = (state==ACCESS && cnt==0). It is decoded from registers only, with no combinational path from bus inputs.
  - ACCESS -> IDLE on the edge where i_psel & i_penable & o_pready; the transfer completes at that edge.
  - ACCESS -> IDLE on the first edge where i_psel=0 (protocol abort); no write, no response.
  - In IDLE, i_psel=1 with i_penable=1 is ignored; the FSM stays in IDLE.
- Latency: setup cycle, then (WAIT_CYCLES+1) access cycles. With WAIT_CYCLES=0 o_pready=1 in the first access cycle. Back-to-back transfers are legal (IDLE accepts the next setup on the cycle after completion).
- Error, evaluated at setup from captured values; err = 1 if any of:
  - paddr[1:0] != 0;
  - paddr >= 4*NREGS;
  - write to index 0 (ID register is read-only).
- o_pslverr = err only while o_pready=1, otherwise 0.
- Erroring transfers never modify registers, and their o_prdata = 0.
- Read: o_prdata = reg[paddr>>2] as captured at setup, driven only while o_pready=1, else 0.
- Write: commits at the completion edge. For each byte b with pstrb[b]=1, reg[idx][8b+:8] <= pwdata[8b+:8]. pstrb = 0 gives a successful no-op write.
- Captured command values are used throughout ACCESS; bus changes during ACCESS are ignored.
- o_pready, o_pslverr and o_prdata are 0 in IDLE.

Decomposition:
- Shared package apb_pkg holds:
  - state_t enum (IDLE=2'b00, ACCESS=2'b10), shared with apb_master;
  - APB_DW=32 and APB_SW=4;
  - the ID_VALUE default.
- Sub-module apb_regfile contains the register array, byte-strobe write port, read mux and o_regs flattening. The FSM, wait counter and address/error decode stay in apb_slave_regs.

Test Plan:
- Write 0xDEADBEEF to 0x04 with pstrb=4'hF, WAIT_CYCLES=0 -> o_pready=1 in the first access cycle, o_pslverr=0. Reading 0x04 then returns 0xDEADBEEF and o_regs[63:32]=0xDEADBEEF.
- Write 0x11223344 with pstrb=4'b0101 to 0x08 when it holds 0 -> reg2 = 0x00220044.
- Reads of 0x03, of 0x20 (NREGS=8), and a write to 0x00 -> each gets o_pslverr=1 with o_pready, o_prdata=0, and reg contents unchanged. Reading 0x00 returns 0xA5B00001 with o_pslverr=0.
- WAIT_CYCLES=3, read 0x04 -> o_pready low for 3 access cycles and high on the 4th. pwdata/paddr toggling during ACCESS has no effect.
- Reset asserted mid-ACCESS of a write to 0x0C -> o_pready=0 on the next cycle and reg3=0. Deasserting psel mid-wait -> FSM back to IDLE, no write.
- Back-to-back write 0x04 then read 0x04 with no idle cycle -> both complete; the read returns the written data.
